// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline multiply/divide sequencer.
// Holds the op and FSM state types plus the default iteration count.
package pipe_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared engine: shift-add multiply or restoring divide
// on the 64-bit working register, with the 33-bit zero-extended operand.
module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] work_in,
  input  logic [32:0] opnd,
  output logic [63:0] work_out
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic [63:0] mul_out;
  logic [63:0] div_out;

  // Multiply: conditional add into {carry, acc}, then shift the whole thing right.
  assign sum     = {1'b0, work_in[63:32]} + (work_in[0] ? opnd : 33'd0);
  assign mul_out = {sum, work_in[31:1]};

  // Divide: the upper 33 bits after a left shift are work_in[63:31]; since the
  // remainder stays below the divisor, bit 32 of the difference is its sign.
  assign trial   = work_in[63:31] - opnd;
  assign div_out = trial[32] ? {work_in[62:0], 1'b0}
                             : {trial[31:0], work_in[30:0], 1'b1};

  assign work_out = is_div ? div_out : mul_out;

endmodule

// File: rtl/pipe_muldiv_ctrl.sv
// Multi-cycle mult/div sequencer beside EX: owns HI/LO, runs the iterative
// engine for a fixed 33-cycle latency and stalls dependent EX instructions.
module pipe_muldiv_ctrl
  import pipe_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        estart,
  input  logic [1:0]  eop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        emfhi,
  input  logic        emflo,
  input  logic        emthi,
  input  logic        emtlo,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e        state_reg, state_next;
  op_e           op_reg, op_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [63:0]   work_reg, work_next;
  logic [32:0]   opnd_reg, opnd_next;
  logic          negq_reg, negq_next;
  logic          negr_reg, negr_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;

  logic          signed_op;
  logic [31:0]   a_abs;
  logic [31:0]   b_abs;
  logic          is_div;
  logic [63:0]   step_out;
  logic [63:0]   prod;

  // Signed ops (mult, div) have a zero low opcode bit.
  assign signed_op = ~eop[0];
  assign a_abs     = (signed_op & ea[31]) ? -ea : ea;
  assign b_abs     = (signed_op & eb[31]) ? -eb : eb;
  assign is_div    = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
  assign prod      = negq_reg ? -work_reg : work_reg;

  muldiv_step u_step (
    .is_div   (is_div),
    .work_in  (work_reg),
    .opnd     (opnd_reg),
    .work_out (step_out)
  );

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    work_next  = work_reg;
    opnd_next  = opnd_reg;
    negq_next  = negq_reg;
    negr_next  = negr_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      S_IDLE: begin
        if (estart) begin
          op_next    = op_e'(eop);
          work_next  = {32'd0, a_abs};
          opnd_next  = {1'b0, b_abs};
          negq_next  = signed_op & (ea[31] ^ eb[31]);
          negr_next  = signed_op & ea[31];
          cnt_next   = '0;
          state_next = S_RUN;
        end else begin
          if (emthi) hi_next = ea;
          if (emtlo) lo_next = ea;
        end
      end
      S_RUN: begin
        work_next = step_out;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST) state_next = S_FIX;
      end
      S_FIX: begin
        // Results become architecturally visible only here.
        if (is_div) begin
          hi_next = negr_reg ? -work_reg[63:32] : work_reg[63:32];
          lo_next = negq_reg ? -work_reg[31:0]  : work_reg[31:0];
        end else begin
          hi_next = prod[63:32];
          lo_next = prod[31:0];
        end
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      op_reg    <= OP_MULT;
      cnt_reg   <= '0;
      work_reg  <= '0;
      opnd_reg  <= '0;
      negq_reg  <= 1'b0;
      negr_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      work_reg  <= work_next;
      opnd_reg  <= opnd_next;
      negq_reg  <= negq_next;
      negr_reg  <= negr_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy  = (state_reg != S_IDLE);
  assign stall = busy & (estart | emfhi | emflo | emthi | emtlo);
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Directed plus randomized checks of pipe_muldiv_ctrl against an arithmetic
// reference of the MIPS mult/div/HI/LO behaviour.
module tb_pipe_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        emfhi;
  logic        emflo;
  logic        emthi;
  logic        emtlo;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_muldiv_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .estart (estart),
    .eop    (eop),
    .ea     (ea),
    .eb     (eb),
    .emfhi  (emfhi),
    .emflo  (emflo),
    .emthi  (emthi),
    .emtlo  (emtlo),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) res = {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Called at a negedge; returns at the negedge after completion with stall low.
  // mode 0: plain, 1: mfhi waiting behind the op, 2: mtlo waiting behind the op.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode);
    logic [63:0] exp;
    logic [31:0] mt_data;
    int busy_cyc;
    int stall_cyc;
    exp = model(op, a, b);
    mt_data = $urandom;
    estart = 1'b1; eop = op; ea = a; eb = b;
    @(negedge clock);
    estart = 1'b0;
    ea = (mode == 2) ? mt_data : $urandom;
    eb = $urandom;
    emfhi = (mode == 1);
    emtlo = (mode == 2);
    busy_cyc = 0;
    stall_cyc = 0;
    while (busy && busy_cyc < 100) begin
      busy_cyc++;
      if (stall) stall_cyc++;
      @(negedge clock);
    end
    chk("latency", 32'(busy_cyc), 32'd33);
    if (mode != 0) chk("stall_cycles", 32'(stall_cyc), 32'd33);
    chk("stall_after", {31'd0, stall}, 32'd0);
    chk("hi", hi, exp[63:32]);
    chk("lo", lo, exp[31:0]);
    if (mode == 2) begin
      @(negedge clock);
      chk("mtlo_deferred", lo, mt_data);
    end
    emfhi = 1'b0;
    emtlo = 1'b0;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d mode=%0d",
             op, a, b, hi, lo, busy_cyc, mode);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;
    resetn = 1'b0; estart = 1'b0; eop = 2'b00; ea = '0; eb = '0;
    emfhi = 1'b0; emflo = 1'b0; emthi = 1'b0; emtlo = 1'b0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    $display("reset: busy=%0b stall=%0b hi=%h lo=%h", busy, stall, hi, lo);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b11, 32'd100, 32'd7, 0);
    do_op(2'b11, 32'd5, 32'd0, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0);

    // mthi in IDLE: no stall, visible after the next edge.
    emthi = 1'b1; ea = 32'h1234_5678;
    #1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    emthi = 1'b0;
    chk("mthi_hi", hi, 32'h1234_5678);
    $display("mthi 12345678 -> hi=%h", hi);

    do_op(2'b01, 32'd9, 32'd11, 2);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = $urandom_range(1, 15);
      else if (sel == 2) ra = 32'h8000_0000;
      do_op(rop, ra, rb, 0);
    end

    // Abort a mult mid-run: state and HI/LO drop to zero at once.
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    estart = 1'b1; eop = 2'b00; ea = 32'h0001_2345; eb = 32'h0000_6789;
    @(negedge clock);
    estart = 1'b0;
    repeat (10) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    $display("abort: busy=%0b hi=%h lo=%h", busy, hi, lo);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    do_op(2'b01, 32'd3, 32'd4, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
